// File: rtl/arp_tbl_reg_bridge_if.sv
// AXI4-Lite signal bundle between the interconnect and the ARP table register bridge.
interface arp_tbl_reg_bridge_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/arp_tbl_reg_bridge.sv
// AXI4-Lite slave staging 96-bit ARP table entries and issuing one-cycle table
// read/write requests, waiting for the ack with a timeout.
//
// state      | meaning
// IDLE       | accepting AXI writes, no table op in flight
// WR_REQ     | tbl_wr_req high for one cycle, addr/data registered
// RD_REQ     | tbl_rd_req high for one cycle, addr registered
// WR_WAIT    | waiting for tbl_wr_ack, timeout counting down
// RD_WAIT    | waiting for tbl_rd_ack, timeout counting down
module arp_tbl_reg_bridge #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_USE_WSTRB        = 0,
  parameter int C_ACK_TIMEOUT      = 16
) (
  input  logic                 AXI_ACLK,
  input  logic                 AXI_RESETN,
  arp_tbl_reg_bridge_if.slave  s_axi,
  output logic                 tbl_wr_req,
  output logic                 tbl_rd_req,
  output logic [4:0]           tbl_wr_addr,
  output logic [4:0]           tbl_rd_addr,
  output logic [95:0]          tbl_wr_data,
  input  logic [95:0]          tbl_rd_data,
  input  logic                 tbl_wr_ack,
  input  logic                 tbl_rd_ack
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_RD_WAIT = 3'd4
  } state_t;

  localparam logic [7:0] LP_TMO    = 8'(C_ACK_TIMEOUT);
  localparam logic [1:0] LP_OKAY   = 2'b00;
  localparam logic [1:0] LP_SLVERR = 2'b10;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [7:0]                    r_cnt;
  logic [7:0]                    w_cnt_nxt;
  logic                          w_tmo_set;
  logic                          w_rd_done;

  logic [2:0][31:0]              r_data;
  logic                          r_timeout;
  logic                          r_last_op;
  logic [4:0]                    r_last_addr;

  logic                          r_bvalid;
  logic [1:0]                    r_bresp;
  logic                          r_rvalid;
  logic [1:0]                    r_rresp;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

  logic [2:0]                    w_wsel;
  logic [2:0]                    w_rsel;
  logic                          w_wr_hs;
  logic                          w_rd_hs;
  logic                          w_wr_trig;
  logic                          w_rd_trig;
  logic                          w_wr_bad;
  logic                          w_busy;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_rdata;
  logic                          w_rd_bad;
  logic                          w_unused_ok;

  assign w_wsel    = s_axi.S_AXI_AWADDR[4:2];
  assign w_rsel    = s_axi.S_AXI_ARADDR[4:2];
  assign w_busy    = (r_state != ST_IDLE);
  assign w_wr_hs   = s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~r_bvalid & ~w_busy;
  assign w_rd_hs   = s_axi.S_AXI_ARVALID & ~r_rvalid;
  assign w_wr_trig = w_wr_hs & (w_wsel == 3'd3);
  assign w_rd_trig = w_wr_hs & (w_wsel == 3'd4);
  assign w_wr_bad  = (w_wsel[2:1] == 2'b11);

  assign w_unused_ok = ^{s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:5], s_axi.S_AXI_AWADDR[1:0],
                         s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:5], s_axi.S_AXI_ARADDR[1:0]};

  assign s_axi.S_AXI_AWREADY = w_wr_hs;
  assign s_axi.S_AXI_WREADY  = w_wr_hs;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_BRESP   = r_bresp;
  assign s_axi.S_AXI_ARREADY = w_rd_hs;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RRESP   = r_rresp;
  assign s_axi.S_AXI_RDATA   = r_rdata;

  assign tbl_wr_req = (r_state == ST_WR_REQ);
  assign tbl_rd_req = (r_state == ST_RD_REQ);

  function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if ((C_USE_WSTRB == 0) || strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tmo_set   = 1'b0;
    w_rd_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_trig)      w_state_nxt = ST_WR_REQ;
        else if (w_rd_trig) w_state_nxt = ST_RD_REQ;
      end
      ST_WR_REQ: begin
        w_state_nxt = ST_WR_WAIT;
        w_cnt_nxt   = LP_TMO;
      end
      ST_RD_REQ: begin
        w_state_nxt = ST_RD_WAIT;
        w_cnt_nxt   = LP_TMO;
      end
      ST_WR_WAIT: begin
        if (tbl_wr_ack) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt <= 8'd1) begin
          w_state_nxt = ST_IDLE;
          w_tmo_set   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_RD_WAIT: begin
        if (tbl_rd_ack) begin
          w_state_nxt = ST_IDLE;
          w_rd_done   = 1'b1;
        end else if (r_cnt <= 8'd1) begin
          w_state_nxt = ST_IDLE;
          w_tmo_set   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Software writes can only land in IDLE, so they never collide with read-back data
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      r_data <= '0;
    end else if (w_rd_done) begin
      r_data <= tbl_rd_data;
    end else if (w_wr_hs) begin
      case (w_wsel)
        3'd0: r_data[0] <= f_merge(r_data[0], s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
        3'd1: r_data[1] <= f_merge(r_data[1], s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
        3'd2: r_data[2] <= f_merge(r_data[2], s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
        default: ;
      endcase
    end
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      tbl_wr_addr <= 5'd0;
      tbl_rd_addr <= 5'd0;
      tbl_wr_data <= '0;
      r_last_op   <= 1'b0;
      r_last_addr <= 5'd0;
    end else if (w_wr_trig) begin
      tbl_wr_addr <= s_axi.S_AXI_WDATA[4:0];
      tbl_wr_data <= r_data;
      r_last_op   <= 1'b0;
      r_last_addr <= s_axi.S_AXI_WDATA[4:0];
    end else if (w_rd_trig) begin
      tbl_rd_addr <= s_axi.S_AXI_WDATA[4:0];
      r_last_op   <= 1'b1;
      r_last_addr <= s_axi.S_AXI_WDATA[4:0];
    end
  end

  // A timeout landing in the same cycle as a STATUS read stays set
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN)                       r_timeout <= 1'b0;
    else if (w_tmo_set)                    r_timeout <= 1'b1;
    else if (w_rd_hs && (w_rsel == 3'd5)) r_timeout <= 1'b0;
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      r_bvalid <= 1'b0;
      r_bresp  <= LP_OKAY;
    end else if (w_wr_hs) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_bad ? LP_SLVERR : LP_OKAY;
    end else if (s_axi.S_AXI_BREADY) begin
      r_bvalid <= 1'b0;
    end
  end

  always_comb begin
    w_rdata  = '0;
    w_rd_bad = 1'b0;
    case (w_rsel)
      3'd0:    w_rdata = r_data[0];
      3'd1:    w_rdata = r_data[1];
      3'd2:    w_rdata = r_data[2];
      3'd3:    w_rdata = {27'd0, tbl_wr_addr};
      3'd4:    w_rdata = {27'd0, tbl_rd_addr};
      3'd5:    w_rdata = {19'd0, r_last_addr, 5'd0, r_last_op, r_timeout, w_busy};
      default: w_rd_bad = 1'b1;
    endcase
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      r_rvalid <= 1'b0;
      r_rresp  <= LP_OKAY;
      r_rdata  <= '0;
    end else if (w_rd_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_rd_bad ? LP_SLVERR : LP_OKAY;
      r_rdata  <= w_rdata;
    end else if (s_axi.S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arp_tbl_reg_bridge.sv
// Directed bench for arp_tbl_reg_bridge: AXI-Lite master tasks plus a table responder
// whose ack delay and behaviour are set per test.
module tb_arp_tbl_reg_bridge;

  logic        clk_sys;
  logic        rst_n;
  logic        tbl_wr_req;
  logic        tbl_rd_req;
  logic [4:0]  tbl_wr_addr;
  logic [4:0]  tbl_rd_addr;
  logic [95:0] tbl_wr_data;
  logic [95:0] tbl_rd_data;
  logic        tbl_wr_ack;
  logic        tbl_rd_ack;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  arp_tbl_reg_bridge_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32)) bus ();

  arp_tbl_reg_bridge #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(32),
    .C_USE_WSTRB       (1),
    .C_ACK_TIMEOUT     (16)
  ) dut (
    .AXI_ACLK    (clk_sys),
    .AXI_RESETN  (rst_n),
    .s_axi       (bus),
    .tbl_wr_req  (tbl_wr_req),
    .tbl_rd_req  (tbl_rd_req),
    .tbl_wr_addr (tbl_wr_addr),
    .tbl_rd_addr (tbl_rd_addr),
    .tbl_wr_data (tbl_wr_data),
    .tbl_rd_data (tbl_rd_data),
    .tbl_wr_ack  (tbl_wr_ack),
    .tbl_rd_ack  (tbl_rd_ack)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // responder: mode 0 = normal ack, 1 = never ack, 2 = ack of the wrong type
  int          rsp_mode = 0;
  int          ack_dly  = 1;
  logic [95:0] mem [0:31];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [4:0]  wr_log [0:7];
  int          wr_cyc [0:7];
  logic [4:0]  rd_log [0:7];
  int          rd_cyc [0:7];
  logic [95:0] last_wr_data;
  logic        pend;
  logic        pend_rd;
  logic [4:0]  pend_addr;
  int          dly;

  initial begin
    tbl_wr_ack   = 1'b0;
    tbl_rd_ack   = 1'b0;
    tbl_rd_data  = '0;
    pend         = 1'b0;
    pend_rd      = 1'b0;
    pend_addr    = '0;
    dly          = 0;
    last_wr_data = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    forever begin
      @(negedge clk_sys);
      tbl_wr_ack = 1'b0;
      tbl_rd_ack = 1'b0;
      if (pend) begin
        if (dly == 0) begin
          pend = 1'b0;
          if (pend_rd ^ (rsp_mode == 2)) begin
            tbl_rd_data = mem[pend_addr];
            tbl_rd_ack  = 1'b1;
          end else begin
            tbl_wr_ack = 1'b1;
          end
        end else begin
          dly = dly - 1;
        end
      end
      if (tbl_wr_req) begin
        if (wr_cnt < 8) begin
          wr_log[wr_cnt] = tbl_wr_addr;
          wr_cyc[wr_cnt] = cyc;
        end
        wr_cnt++;
        last_wr_data     = tbl_wr_data;
        mem[tbl_wr_addr] = tbl_wr_data;
        if (rsp_mode != 1) begin
          pend = 1'b1; pend_rd = 1'b0; pend_addr = tbl_wr_addr; dly = ack_dly;
        end
      end
      if (tbl_rd_req) begin
        if (rd_cnt < 8) begin
          rd_log[rd_cnt] = tbl_rd_addr;
          rd_cyc[rd_cnt] = cyc;
        end
        rd_cnt++;
        if (rsp_mode != 1) begin
          pend = 1'b1; pend_rd = 1'b1; pend_addr = tbl_rd_addr; dly = ack_dly;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  int hs_cyc;

  task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output logic [1:0] resp);
    int n;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    n = 0;
    @(negedge clk_sys);
    while (!bus.S_AXI_AWREADY && n < 200) begin
      n++;
      @(negedge clk_sys);
    end
    if (!bus.S_AXI_AWREADY) chk("aw_handshake_timeout", 96'd0, 96'd1);
    if (bus.S_AXI_WREADY !== bus.S_AXI_AWREADY) chk("wready_with_awready", 96'(bus.S_AXI_WREADY), 96'(bus.S_AXI_AWREADY));
    hs_cyc = cyc;
    @(posedge clk_sys); #1;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    n = 0;
    @(negedge clk_sys);
    while (!bus.S_AXI_BVALID && n < 20) begin
      n++;
      @(negedge clk_sys);
    end
    if (!bus.S_AXI_BVALID) chk("bvalid_timeout", 96'd0, 96'd1);
    resp = bus.S_AXI_BRESP;
    @(posedge clk_sys); #1;
  endtask

  task automatic axi_rd(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    n = 0;
    @(negedge clk_sys);
    while (!bus.S_AXI_ARREADY && n < 50) begin
      n++;
      @(negedge clk_sys);
    end
    if (!bus.S_AXI_ARREADY) chk("ar_handshake_timeout", 96'd0, 96'd1);
    @(posedge clk_sys); #1;
    bus.S_AXI_ARVALID = 1'b0;
    n = 0;
    @(negedge clk_sys);
    while (!bus.S_AXI_RVALID && n < 20) begin
      n++;
      @(negedge clk_sys);
    end
    if (!bus.S_AXI_RVALID) chk("rvalid_timeout", 96'd0, 96'd1);
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    @(posedge clk_sys); #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic test_wr_entry(input string pfx);
    logic [1:0] resp;
    wr_cnt = 0;
    axi_wr(32'h00, 32'hAABBCCDD, 4'hF, resp);
    axi_wr(32'h04, 32'h11223344, 4'hF, resp);
    axi_wr(32'h08, 32'h0000BEEF, 4'hF, resp);
    axi_wr(32'h0C, 32'h00000005, 4'hF, resp);
    chk({pfx, "_bresp"}, 96'(resp), 96'd0);
    wait_cyc(10);
    chk({pfx, "_wr_pulses"}, 96'(wr_cnt), 96'd1);
    chk({pfx, "_wr_addr"}, 96'(wr_log[0]), 96'd5);
    chk({pfx, "_wr_data"}, last_wr_data, 96'h0000BEEF_11223344_AABBCCDD);
  endtask

  logic [31:0] rd_d;
  logic [1:0]  rd_r;
  logic [1:0]  wr_r;

  initial begin
    rst_n             = 1'b0;
    bus.S_AXI_AWADDR  = '0;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA   = '0;
    bus.S_AXI_WSTRB   = '0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b1;
    bus.S_AXI_ARADDR  = '0;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1 rst_n = 1'b1;
    wait_cyc(1);

    // reset state
    chk("rst_wr_req", 96'(tbl_wr_req), 96'd0);
    chk("rst_bvalid", 96'(bus.S_AXI_BVALID), 96'd0);
    chk("rst_wr_data", tbl_wr_data, 96'd0);
    axi_rd(32'h14, rd_d, rd_r);
    chk("rst_status", 96'(rd_d), 96'd0);
    chk("rst_rresp", 96'(rd_r), 96'd0);

    // table write
    test_wr_entry("t1");

    // table read back into DATA0..2
    axi_wr(32'h00, 32'h0, 4'hF, wr_r);
    axi_wr(32'h04, 32'h0, 4'hF, wr_r);
    axi_wr(32'h08, 32'h0, 4'hF, wr_r);
    rd_cnt = 0;
    axi_wr(32'h10, 32'h5, 4'hF, wr_r);
    wait_cyc(10);
    chk("t2_rd_pulses", 96'(rd_cnt), 96'd1);
    chk("t2_rd_addr", 96'(rd_log[0]), 96'd5);
    axi_rd(32'h00, rd_d, rd_r); chk("t2_data0", 96'(rd_d), 96'hAABBCCDD);
    axi_rd(32'h04, rd_d, rd_r); chk("t2_data1", 96'(rd_d), 96'h11223344);
    axi_rd(32'h08, rd_d, rd_r); chk("t2_data2", 96'(rd_d), 96'h0000BEEF);
    axi_rd(32'h14, rd_d, rd_r); chk("t2_status", 96'(rd_d), 96'h0504);

    // timeout, with a wrong-type ack arriving mid-wait
    rsp_mode = 2;
    ack_dly  = 2;
    rd_cnt   = 0;
    axi_wr(32'h10, 32'h3, 4'hF, wr_r);
    chk("t3_trig_bresp", 96'(wr_r), 96'd0);
    axi_rd(32'h14, rd_d, rd_r); chk("t3_status_busy", 96'(rd_d), 96'h0305);
    axi_wr(32'h08, 32'h0000BEEF, 4'hF, wr_r);
    chk("t3_idle_after_cycles", 96'(hs_cyc - rd_cyc[0]), 96'd17);
    axi_rd(32'h14, rd_d, rd_r); chk("t3_status_tmo", 96'(rd_d), 96'h0306);
    axi_rd(32'h14, rd_d, rd_r); chk("t3_status_clr", 96'(rd_d), 96'h0304);
    axi_rd(32'h00, rd_d, rd_r); chk("t3_data0_kept", 96'(rd_d), 96'hAABBCCDD);

    // back-to-back triggers
    rsp_mode = 0;
    ack_dly  = 4;
    wr_cnt   = 0;
    axi_wr(32'h0C, 32'h1, 4'hF, wr_r);
    axi_wr(32'h0C, 32'h2, 4'hF, wr_r);
    wait_cyc(20);
    chk("t4_wr_pulses", 96'(wr_cnt), 96'd2);
    chk("t4_first_addr", 96'(wr_log[0]), 96'd1);
    chk("t4_second_addr", 96'(wr_log[1]), 96'd2);
    chk("t4_req_spacing", 96'(wr_cyc[1] - wr_cyc[0]), 96'd7);
    axi_rd(32'h0C, rd_d, rd_r); chk("t4_wr_addr_reg", 96'(rd_d), 96'd2);
    axi_rd(32'h14, rd_d, rd_r); chk("t4_status", 96'(rd_d), 96'h0200);

    // byte strobes and unmapped addresses
    ack_dly = 1;
    axi_wr(32'h00, 32'h0, 4'hF, wr_r);
    axi_wr(32'h00, 32'hFFFFFFFF, 4'b0001, wr_r);
    axi_rd(32'h00, rd_d, rd_r); chk("t5_strb_byte0", 96'(rd_d), 96'h000000FF);
    axi_wr(32'h00, 32'h12345678, 4'b0100, wr_r);
    axi_rd(32'h00, rd_d, rd_r); chk("t5_strb_byte2", 96'(rd_d), 96'h003400FF);
    axi_rd(32'h18, rd_d, rd_r);
    chk("t5_unmapped_rdata", 96'(rd_d), 96'd0);
    chk("t5_unmapped_rresp", 96'(rd_r), 96'd2);
    axi_wr(32'h1C, 32'hDEADBEEF, 4'hF, wr_r);
    chk("t5_unmapped_bresp", 96'(wr_r), 96'd2);
    axi_rd(32'h00, rd_d, rd_r);
    chk("t5_data0_after_unmapped", 96'(rd_d), 96'h003400FF);
    chk("t5_mapped_rresp", 96'(rd_r), 96'd0);

    // reset while in RD_WAIT
    rsp_mode = 1;
    axi_wr(32'h10, 32'h7, 4'hF, wr_r);
    wait_cyc(3);
    chk("t6_rd_addr_pre", 96'(tbl_rd_addr), 96'd7);
    rst_n = 1'b0;
    #1;
    chk("t6_rd_req_in_rst", 96'(tbl_rd_req), 96'd0);
    chk("t6_rd_addr_in_rst", 96'(tbl_rd_addr), 96'd0);
    chk("t6_wr_data_in_rst", tbl_wr_data, 96'd0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(1);
    rsp_mode = 0;
    axi_rd(32'h14, rd_d, rd_r); chk("t6_status", 96'(rd_d), 96'd0);
    axi_rd(32'h00, rd_d, rd_r); chk("t6_data0", 96'(rd_d), 96'd0);
    axi_rd(32'h04, rd_d, rd_r); chk("t6_data1", 96'(rd_d), 96'd0);
    axi_rd(32'h08, rd_d, rd_r); chk("t6_data2", 96'(rd_d), 96'd0);
    test_wr_entry("t6_t1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
